// File: rtl/pipeline_run_controller.sv
// Run/step sequencer for the five-stage pipeline: starts execution,
// drains the pipeline after a decoded halt and counts enabled cycles.
module pipeline_run_controller #(
  parameter int NB_CYCLES    = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start_continuous,
  input  logic                 i_start_step,
  input  logic                 i_abort,
  input  logic                 i_halt_decoded,
  output logic                 o_pipeline_enable,
  output logic                 o_pc_enable,
  output logic                 o_flush_id,
  output logic                 o_done,
  output logic [2:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP      = 3'd2,
    WAIT_STEP = 3'd3,
    DRAIN     = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [NB_CYCLES-1:0] CNT_ONE = NB_CYCLES'(1);

  state_t               state_q, state_d;
  logic [3:0]           drain_q, drain_d;
  logic [NB_CYCLES-1:0] count_q;
  logic                 clr_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    clr_count = 1'b0;
    if (i_abort) begin
      state_d = IDLE;
      drain_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start_continuous) begin
            state_d   = RUN;
            clr_count = 1'b1;
          end else if (i_start_step) begin
            state_d   = STEP;
            clr_count = 1'b1;
          end
        end
        RUN: begin
          if (i_halt_decoded) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
        STEP: begin
          if (i_halt_decoded) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = WAIT_STEP;
          end
        end
        WAIT_STEP: begin
          if (i_start_continuous) state_d = RUN;
          else if (i_start_step)  state_d = STEP;
        end
        DRAIN: begin
          if (drain_q == 4'd0) state_d = DONE;
          else                 drain_d = drain_q - 4'd1;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_pipeline_enable = (state_q == RUN) || (state_q == STEP) ||
                        (state_q == DRAIN);
    // PC must not capture the instruction fetched behind a halt.
    o_pc_enable = ((state_q == RUN) || (state_q == STEP)) &&
                  !i_halt_decoded;
    o_flush_id  = (state_q == DRAIN);
    o_done      = (state_q == DONE);
    o_state     = state_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (clr_count) begin
      count_q <= '0;
    end else if (o_pipeline_enable && !(&count_q)) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  assign o_cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: vector table, directed corner
// sequences and random stimulus against a phase-level reference model.
module tb_pipeline_run_controller;

  localparam int DR = 4;
  localparam longint MAX32 = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic c_i, s_i, a_i, h_i;
  logic en, pc, fl, dn;
  logic [2:0] st;
  logic [31:0] cnt;
  logic en4, pc4, fl4, dn4;
  logic [2:0] st4;
  logic [3:0] cnt4;

  always #5 clk = ~clk;

  pipeline_run_controller #(.NB_CYCLES(32), .DRAIN_CYCLES(DR)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_start_continuous(c_i), .i_start_step(s_i),
    .i_abort(a_i), .i_halt_decoded(h_i),
    .o_pipeline_enable(en), .o_pc_enable(pc),
    .o_flush_id(fl), .o_done(dn),
    .o_state(st), .o_cycle_count(cnt)
  );

  pipeline_run_controller #(.NB_CYCLES(4), .DRAIN_CYCLES(DR)) dut_sat (
    .i_clk(clk), .i_reset(rst),
    .i_start_continuous(c_i), .i_start_step(s_i),
    .i_abort(a_i), .i_halt_decoded(h_i),
    .o_pipeline_enable(en4), .o_pc_enable(pc4),
    .o_flush_id(fl4), .o_done(dn4),
    .o_state(st4), .o_cycle_count(cnt4)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one flag per activity phase plus drain cycles left.
  bit m_free, m_single, m_parked, m_done;
  int m_drain;
  longint m_cnt, m_cnt4;

  typedef struct {
    bit c, s, a, h;
    int st;
    bit en, pc, fl, dn;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(bit c, bit s, bit a, bit h, int st,
                              bit en, bit pc, bit fl, bit dn);
    vec_t v;
    v.c = c; v.s = s; v.a = a; v.h = h; v.st = st;
    v.en = en; v.pc = pc; v.fl = fl; v.dn = dn;
    return v;
  endfunction

  function automatic int m_state();
    if (m_drain > 0) return 4;
    if (m_done)      return 5;
    if (m_free)      return 1;
    if (m_single)    return 2;
    if (m_parked)    return 3;
    return 0;
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic go_idle();
    m_free = 0; m_single = 0; m_parked = 0; m_done = 0; m_drain = 0;
  endtask

  task automatic model_reset();
    go_idle();
    m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_check();
    bit ex_en;
    ex_en = m_free || m_single || (m_drain > 0);
    chk("state", st, m_state());
    chk("enable", en, ex_en);
    chk("pc_enable", pc, (m_free || m_single) && !h_i);
    chk("flush", fl, m_drain > 0);
    chk("done", dn, m_done);
    chk("count", cnt, m_cnt);
    chk("count4", cnt4, m_cnt4);
    chk("state4", st4, m_state());
  endtask

  task automatic model_update();
    if (m_free || m_single || m_drain > 0) begin
      if (m_cnt < MAX32) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (a_i) begin
      go_idle();
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 1;
    end else if (m_free) begin
      if (h_i) begin m_free = 0; m_drain = DR; end
    end else if (m_single) begin
      m_single = 0;
      if (h_i) m_drain = DR;
      else     m_parked = 1;
    end else if (m_parked) begin
      if (c_i)      begin m_parked = 0; m_free = 1; end
      else if (s_i) begin m_parked = 0; m_single = 1; end
    end else begin
      if (c_i)      begin m_free = 1;   m_cnt = 0; m_cnt4 = 0; end
      else if (s_i) begin m_single = 1; m_cnt = 0; m_cnt4 = 0; end
    end
  endtask

  task automatic apply(input bit c, input bit s, input bit a, input bit h);
    @(negedge clk);
    c_i = c; s_i = s; a_i = a; h_i = h;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input bit c, input bit s, input bit a, input bit h);
    apply(c, s, a, h);
    tick();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].c, tbl[i].s, tbl[i].a, tbl[i].h);
      chk($sformatf("%s%0d_state", tag, i), st, tbl[i].st);
      chk($sformatf("%s%0d_en", tag, i), en, tbl[i].en);
      chk($sformatf("%s%0d_pc", tag, i), pc, tbl[i].pc);
      chk($sformatf("%s%0d_flush", tag, i), fl, tbl[i].fl);
      chk($sformatf("%s%0d_done", tag, i), dn, tbl[i].dn);
      tick();
    end
    #1;
    chk({tag, "_count"}, cnt, 10);
  endtask

  initial begin
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
    tbl[6] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0);
    for (int i = 7; i <= 10; i++) tbl[i] = mk(0, 0, 0, 0, 4, 1, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 5, 0, 0, 0, 1);
    tbl[12] = mk(1, 1, 0, 0, 5, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 5, 0, 0, 0, 1);

    rst = 1'b1;
    c_i = 0; s_i = 0; a_i = 0; h_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", st, 0);
    chk("rst_en", en, 0);
    chk("rst_done", dn, 0);
    chk("rst_count", cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    run_table("cont");

    // Stepping, with an extra pulse landing while in STEP.
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0);
      cyc(0, k == 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    apply(0, 0, 0, 0);
    chk("step_state", st, 3);
    chk("step_count", cnt, 3);
    tick();

    // Halt present during the step cycle.
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    apply(0, 0, 0, 1);
    chk("hstep_state", st, 2);
    chk("hstep_pc", pc, 0);
    tick();
    repeat (4) cyc(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    chk("hstep_done", dn, 1);
    chk("hstep_count", cnt, 5);
    tick();

    // Abort in the second drain cycle.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    apply(0, 0, 1, 0);
    chk("abrt_pre_state", st, 4);
    tick();
    apply(0, 0, 0, 0);
    chk("abrt_state", st, 0);
    chk("abrt_en", en, 0);
    chk("abrt_flush", fl, 0);
    chk("abrt_done", dn, 0);
    chk("abrt_count", cnt, 5);
    tick();
    cyc(0, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("abrt_kept", cnt, 5);
    tick();
    apply(0, 0, 0, 0);
    chk("restart_clr", cnt, 0);
    chk("restart_state", st, 1);
    tick();

    // Both starts together from IDLE, then async reset mid-RUN.
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    apply(0, 0, 0, 0);
    chk("both_state", st, 1);
    tick();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_state", st, 0);
    chk("arst_en", en, 0);
    chk("arst_pc", pc, 0);
    chk("arst_flush", fl, 0);
    chk("arst_done", dn, 0);
    chk("arst_count", cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_table("post");

    // Saturation of the 4-bit counter instance.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (19) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    chk("sat_done", dn, 1);
    chk("sat_count4", cnt4, 15);
    chk("sat_count32", cnt, 24);
    tick();

    repeat (400) begin
      cyc($urandom % 12 == 0, $urandom % 5 == 0,
          $urandom % 40 == 0, $urandom % 6 == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
